fpu_unpack_stage: RTL and testbench

Parametrised first stage of the pipelined FPU. It accepts two packed IEEE-754 operands of configurable format. For each operand it:
- inserts the correct hidden bit;
- normalises the subnormal exponent;
- fully classifies the operand (zero / subnormal / normal / inf / qNaN / sNaN).

Outputs are registered behind a 2-entry skid buffer with valid/ready handshake, so downstream stages can stall without combinational ready paths.

---
 rtl/fpu_unpack_stage.sv | 171 +++++++++++++++++
 tb/tb_fpu_unpack_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_unpack_stage.sv
// ============================================================================
// Module   : fpu_unpack_stage
// Brief    : FPU front stage. Unpacks and classifies two IEEE-754 operands
//            behind a 2-entry skid buffer. Optional FPU_UNPACK_DAZ_EN macro
//            makes subnormal operands read as zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_unpack_stage #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [EXP_W+MANT_W:0]   a_i,
  input  logic [EXP_W+MANT_W:0]   b_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    a_sign_o,
  output logic                    b_sign_o,
  output logic [EXP_W-1:0]        a_exp_o,
  output logic [EXP_W-1:0]        b_exp_o,
  output logic [MANT_W:0]         a_mant_o,
  output logic [MANT_W:0]         b_mant_o,
  output logic [2:0]              a_class_o,
  output logic [2:0]              b_class_o,
  output logic [1:0]              num_status_o
);

  localparam int OP_W   = EXP_W + MANT_W + 5;
  localparam int PAIR_W = 2 * OP_W + 2;

  localparam logic [2:0] CLS_ZERO = 3'b000;
  localparam logic [2:0] CLS_SUB  = 3'b001;
  localparam logic [2:0] CLS_NORM = 3'b010;
  localparam logic [2:0] CLS_INF  = 3'b011;
  localparam logic [2:0] CLS_QNAN = 3'b100;
  localparam logic [2:0] CLS_SNAN = 3'b101;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b01;
  localparam logic [1:0] ST_INF  = 2'b10;
  localparam logic [1:0] ST_NAN  = 2'b11;

  // Operand record layout, LSB first: sign, exp, {hidden, frac}, class.
  function automatic logic [OP_W-1:0] unpack_op(input logic [EXP_W+MANT_W:0] x);
    logic              sign;
    logic [EXP_W-1:0]  e;
    logic [EXP_W-1:0]  eo;
    logic [MANT_W-1:0] f;
    logic              hid;
    logic [2:0]        cls;
    sign = x[EXP_W+MANT_W];
    e    = x[EXP_W+MANT_W-1:MANT_W];
    f    = x[MANT_W-1:0];
    eo   = e;
    hid  = 1'b1;
    cls  = CLS_NORM;
    if (e == '0) begin
      hid = 1'b0;
      if (f == '0) begin
        cls = CLS_ZERO;
        eo  = '0;
      end else begin
`ifdef FPU_UNPACK_DAZ_EN
        cls = CLS_ZERO;
        eo  = '0;
        f   = '0;
`else
        // Subnormals share the exponent of the smallest normal.
        cls = CLS_SUB;
        eo  = {{(EXP_W-1){1'b0}}, 1'b1};
`endif
      end
    end else if (e == '1) begin
      if (f == '0)              cls = CLS_INF;
      else if (f[MANT_W-1])     cls = CLS_QNAN;
      else                      cls = CLS_SNAN;
    end
    return {cls, hid, f, eo, sign};
  endfunction

  function automatic logic [1:0] pair_status(input logic [2:0] ca, input logic [2:0] cb);
    logic [1:0] st;
    if (ca == CLS_QNAN || ca == CLS_SNAN || cb == CLS_QNAN || cb == CLS_SNAN)
      st = ST_NAN;
    else if (ca == CLS_INF || cb == CLS_INF)
      st = ST_INF;
    else if (ca == CLS_ZERO && cb == CLS_ZERO)
      st = ST_ZERO;
    else
      st = ST_OK;
    return st;
  endfunction

  logic [OP_W-1:0]   a_op;
  logic [OP_W-1:0]   b_op;
  logic [PAIR_W-1:0] in_pair;

  always_comb begin
    a_op    = unpack_op(a_i);
    b_op    = unpack_op(b_i);
    in_pair = {pair_status(a_op[OP_W-1:OP_W-3], b_op[OP_W-1:OP_W-3]), b_op, a_op};
  end

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [PAIR_W-1:0] main_q, main_d;
  logic [PAIR_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              drain;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    accept       = valid_i && !skid_valid_q;
    drain        = main_valid_q && ready_i;

    if (!main_valid_q || drain) begin
      // Skid full implies no accept this cycle, so it always refills main first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_pair;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_pair;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign ready_o      = !skid_valid_q;
  assign valid_o      = main_valid_q;

  assign a_sign_o     = main_q[0];
  assign a_exp_o      = main_q[EXP_W:1];
  assign a_mant_o     = main_q[EXP_W+MANT_W+1:EXP_W+1];
  assign a_class_o    = main_q[OP_W-1:OP_W-3];
  assign b_sign_o     = main_q[OP_W];
  assign b_exp_o      = main_q[OP_W+EXP_W:OP_W+1];
  assign b_mant_o     = main_q[OP_W+EXP_W+MANT_W+1:OP_W+EXP_W+1];
  assign b_class_o    = main_q[2*OP_W-1:2*OP_W-3];
  assign num_status_o = main_q[PAIR_W-1:PAIR_W-2];

endmodule

`default_nettype wire

// File: tb/tb_fpu_unpack_stage.sv
// Scoreboard bench for fpu_unpack_stage: binary32 instance with directed and
// random traffic, plus a binary64 instance for the wide-format case.
`default_nettype none

module tb_fpu_unpack_stage;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [2:0]  c;
  } op_t;

  typedef struct packed {
    op_t        a;
    op_t        b;
    logic [1:0] st;
  } pair_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, valid_o;
  logic        a_sign_o, b_sign_o;
  logic [7:0]  a_exp_o, b_exp_o;
  logic [23:0] a_mant_o, b_mant_o;
  logic [2:0]  a_class_o, b_class_o;
  logic [1:0]  num_status_o;

  logic [63:0] a64, b64;
  logic        rdy64_o, vld64_o;
  logic        a_sign64, b_sign64;
  logic [10:0] a_exp64, b_exp64;
  logic [52:0] a_mant64, b_mant64;
  logic [2:0]  a_cls64, b_cls64;
  logic [1:0]  st64;

  int    tests = 0;
  int    fails = 0;
  int    pop_cnt = 0;
  bit    rand_rdy = 0;
  pair_t sb_q[$];

  always #5 clk_i = ~clk_i;

  fpu_unpack_stage u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .a_sign_o(a_sign_o), .b_sign_o(b_sign_o), .a_exp_o(a_exp_o), .b_exp_o(b_exp_o),
    .a_mant_o(a_mant_o), .b_mant_o(b_mant_o), .a_class_o(a_class_o), .b_class_o(b_class_o),
    .num_status_o(num_status_o)
  );

  fpu_unpack_stage #(.EXP_W(11), .MANT_W(52)) u_dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(1'b1), .ready_o(rdy64_o),
    .a_i(a64), .b_i(b64), .valid_o(vld64_o), .ready_i(1'b1),
    .a_sign_o(a_sign64), .b_sign_o(b_sign64), .a_exp_o(a_exp64), .b_exp_o(b_exp64),
    .a_mant_o(a_mant64), .b_mant_o(b_mant64), .a_class_o(a_cls64), .b_class_o(b_cls64),
    .num_status_o(st64)
  );

  // Reference model: classification straight from the IEEE field rules.
  function automatic op_t ref_op(input logic [31:0] x);
    op_t r;
    int  e, f;
    e   = int'(x[30:23]);
    f   = int'(x[22:0]);
    r.s = x[31];
    if (e == 0 && f == 0) begin
      r.e = 0; r.m = 0; r.c = 3'd0;
    end else if (e == 0) begin
`ifdef FPU_UNPACK_DAZ_EN
      r.e = 0; r.m = 0; r.c = 3'd0;
`else
      r.e = 8'd1; r.m = 24'(f); r.c = 3'd1;
`endif
    end else begin
      r.e = 8'(e);
      r.m = 24'(8388608 + f);
      if (e < 255)            r.c = 3'd2;
      else if (f == 0)        r.c = 3'd3;
      else if (f >= 4194304)  r.c = 3'd4;
      else                    r.c = 3'd5;
    end
    return r;
  endfunction

  function automatic pair_t ref_pair(input logic [31:0] a, input logic [31:0] b);
    pair_t p;
    bit    nan_a, nan_b;
    p.a   = ref_op(a);
    p.b   = ref_op(b);
    nan_a = (p.a.c == 3'd4 || p.a.c == 3'd5);
    nan_b = (p.b.c == 3'd4 || p.b.c == 3'd5);
    if (nan_a || nan_b)                      p.st = 2'b11;
    else if (p.a.c == 3'd3 || p.b.c == 3'd3) p.st = 2'b10;
    else if (p.a.c == 3'd0 && p.b.c == 3'd0) p.st = 2'b01;
    else                                     p.st = 2'b00;
    return p;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 3))
      0:       f = '0;
      1:       f = 23'd1;
      2:       f = 23'h400000 | 23'($urandom);
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Called at a falling edge; returns at the falling edge after the pair is taken.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit done;
    done    = 0;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (ready_o) begin
        sb_q.push_back(ref_pair(a, b));
        done = 1;
      end
      @(negedge clk_i);
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: ready_o=%0b required 1 within 100 cycles", ready_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops expected pair on each transfer-out, checks hold while stalled.
  initial begin
    pair_t exp_p, act_p, held;
    bit    stall_chk;
    stall_chk = 0;
    held      = '0;
    forever begin
      @(negedge clk_i);
      #2;
      act_p.a  = {a_sign_o, a_exp_o, a_mant_o, a_class_o};
      act_p.b  = {b_sign_o, b_exp_o, b_mant_o, b_class_o};
      act_p.st = num_status_o;
      if (!rst_ni) begin
        stall_chk = 0;
      end else begin
        if (stall_chk) begin
          tests++;
          if (!valid_o || act_p !== held) begin
            fails++;
            $display("FAIL hold: valid_o=%0b pair=%h required valid_o=1 pair=%h", valid_o, act_p, held);
          end
        end
        if (valid_o && ready_i) begin
          tests++;
          pop_cnt++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out: pair=%h with empty scoreboard", act_p);
          end else begin
            exp_p = sb_q.pop_front();
            if (act_p !== exp_p) begin
              fails++;
              $display("FAIL pair: actual a=%h b=%h st=%b required a=%h b=%h st=%b",
                       act_p.a, act_p.b, act_p.st, exp_p.a, exp_p.b, exp_p.st);
            end
          end
        end
        stall_chk = valid_o && !ready_i;
        held      = act_p;
      end
    end
  end

  initial begin
    int p0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    a64     = 64'h3FF0000000000000;
    b64     = 64'h0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_data", 64'({a_exp_o, a_mant_o, b_class_o, num_status_o}), 64'd0);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check("wide_norm", {vld64_o, a_exp64, a_mant64[52:49], a_cls64}, {1'b1, 11'd1023, 4'h8, 3'd2});
    @(negedge clk_i);

    // Directed operand patterns.
    send(32'h3F800000, 32'hC0000000);
    send(32'h00000000, 32'h80000000);
    send(32'h7F800000, 32'h7FC00000);
    send(32'h00000001, 32'h7F800001);
    send(32'h00400000, 32'h3F800000);
    repeat (3) @(negedge clk_i);

    // Backpressure: two pairs buffered, third held upstream.
    ready_i = 1'b0;
    send(32'h3F800000, 32'h40000000);
    send(32'h40400000, 32'h40800000);
    #1;
    check("bp_ready_low", 64'(ready_o), 64'd0);
    a_i = 32'h40A00000; b_i = 32'h40C00000; valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("bp_stalled", {valid_o, ready_o}, 64'b10);
    @(negedge clk_i);
    ready_i = 1'b1;
    p0 = pop_cnt;
    send(32'h40A00000, 32'h40C00000);
    #1;
    check("bp_recover", {valid_o, ready_o}, 64'b11);
    @(negedge clk_i);
    #1;
    check("bp_no_bubble", 64'(pop_cnt - p0), 64'd3);
    @(negedge clk_i);

    // Asynchronous reset while stalled with both entries full.
    ready_i = 1'b0;
    send(32'h41000000, 32'h41100000);
    send(32'h41200000, 32'h41300000);
    repeat (2) @(negedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("async_rst", {valid_o, ready_o, a_exp_o, b_mant_o, num_status_o}, {2'b01, 8'd0, 24'd0, 2'd0});
    sb_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    check("post_rst_empty", 64'(valid_o), 64'd0);
    @(negedge clk_i);

    // Random traffic with random downstream stalls.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
      send(rand_op(), rand_op());
    end
    rand_rdy = 0;
    @(negedge clk_i);
    ready_i = 1'b1;
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    check("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
